// File: rtl/calc1_op_arbiter.sv
// calc1_op_arbiter: age-ordered (FCFS) grant of the shared arith and shift units.
// Ports: c_clk, reset (sync, active-high); req_vld/req_cls per port; arith_rdy,
// shift_rdy; one-hot arith_gnt/shift_gnt with arith_pid/shift_pid (registered
// one-cycle pulses); sticky per-port proto_err.
// Option: CALC1_ARB_RR_TIE_EN orders same-cycle enqueues by a rotating pointer.
module calc1_op_arbiter #(
  parameter int NPORT = 4,
  parameter int PIDW  = 2
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [NPORT-1:0] req_vld,
  input  logic [NPORT-1:0] req_cls,
  input  logic             arith_rdy,
  input  logic             shift_rdy,
  output logic [NPORT-1:0] arith_gnt,
  output logic [NPORT-1:0] shift_gnt,
  output logic [PIDW-1:0]  arith_pid,
  output logic [PIDW-1:0]  shift_pid,
  output logic [NPORT-1:0] proto_err
);
  localparam int CW = PIDW + 1;

  // Queue 0 feeds the arith unit, queue 1 the shift unit.
  logic [PIDW-1:0]  q_r   [2][NPORT];
  logic [PIDW-1:0]  q_n   [2][NPORT];
  logic [CW-1:0]    cnt_r [2];
  logic [CW-1:0]    cnt_n [2];
  logic [PIDW-1:0]  head  [2];
  logic [PIDW-1:0]  ord   [NPORT];
  logic [NPORT-1:0] pend_r;
  logic [NPORT-1:0] pend_n;
  logic [NPORT-1:0] cls_r;
  logic [NPORT-1:0] cls_n;
  logic [NPORT-1:0] err_n;
  logic [NPORT-1:0] push;
  logic [NPORT-1:0] purge;
  logic [1:0]       rdy;
  logic [1:0]       pop;

`ifdef CALC1_ARB_RR_TIE_EN
  logic [PIDW-1:0] rr_r;
  logic [PIDW-1:0] rr_n;

  // Push order starts at the pointer; the pointer then moves
  // one past the last port pushed this cycle.
  always_comb begin
    rr_n = rr_r;
    for (int k = 0; k < NPORT; k++) begin
      ord[k] = PIDW'((int'(rr_r) + k) % NPORT);
    end
    for (int k = 0; k < NPORT; k++) begin
      if (push[ord[k]]) begin
        rr_n = PIDW'((int'(ord[k]) + 1) % NPORT);
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) rr_r <= '0;
    else       rr_r <= rr_n;
  end
`else
  always_comb begin
    for (int k = 0; k < NPORT; k++) begin
      ord[k] = PIDW'(k);
    end
  end
`endif

  always_comb begin
    int n;
    rdy    = {shift_rdy, arith_rdy};
    purge  = pend_r & ~req_vld;
    // A port seen in its grant cycle is not re-queued.
    push   = req_vld & ~pend_r & ~(arith_gnt | shift_gnt);
    err_n  = proto_err | (req_vld & pend_r & (req_cls ^ cls_r));
    cls_n  = (cls_r & ~push) | (req_cls & push);
    pend_n = (pend_r & ~purge) | push;
    pop    = '0;
    for (int u = 0; u < 2; u++) begin
      head[u] = q_r[u][0];
      // A withdrawn head has req_vld=0, so it can never pop.
      pop[u]  = (cnt_r[u] != '0) && rdy[u] &&
                req_vld[head[u]];
      if (pop[u]) pend_n[head[u]] = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        q_n[u][i] = '0;
      end
      // Compact survivors (purge, then pop), then append pushes.
      n = 0;
      for (int i = 0; i < NPORT; i++) begin
        if (i < int'(cnt_r[u]) &&
            !purge[q_r[u][i]] &&
            !(i == 0 && pop[u])) begin
          q_n[u][PIDW'(n)] = q_r[u][i];
          n++;
        end
      end
      for (int k = 0; k < NPORT; k++) begin
        if (push[ord[k]] &&
            int'(req_cls[ord[k]]) == u) begin
          q_n[u][PIDW'(n)] = ord[k];
          n++;
        end
      end
      cnt_n[u] = CW'(n);
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        cnt_r[u] <= '0;
        for (int i = 0; i < NPORT; i++) begin
          q_r[u][i] <= '0;
        end
      end
      pend_r    <= '0;
      cls_r     <= '0;
      proto_err <= '0;
      arith_gnt <= '0;
      shift_gnt <= '0;
      arith_pid <= '0;
      shift_pid <= '0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        cnt_r[u] <= cnt_n[u];
        for (int i = 0; i < NPORT; i++) begin
          q_r[u][i] <= q_n[u][i];
        end
      end
      pend_r    <= pend_n;
      cls_r     <= cls_n;
      proto_err <= err_n;
      arith_gnt <= pop[0] ? (NPORT'(1) << head[0]) : '0;
      shift_gnt <= pop[1] ? (NPORT'(1) << head[1]) : '0;
      arith_pid <= pop[0] ? head[0] : '0;
      shift_pid <= pop[1] ? head[1] : '0;
    end
  end
endmodule

// File: tb/tb_calc1_op_arbiter.sv
// tb_calc1_op_arbiter: directed and random stimulus for calc1_op_arbiter,
// scoreboard of expected grants produced by a queue-level reference model.
module tb_calc1_op_arbiter;
  localparam int NP = 4;
  typedef struct { int port; int cyc; } exp_t;

  logic          c_clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] req_vld = '0;
  logic [NP-1:0] req_cls = '0;
  logic          arith_rdy = 1'b0;
  logic          shift_rdy = 1'b0;
  logic [NP-1:0] arith_gnt;
  logic [NP-1:0] shift_gnt;
  logic [NP-1:0] proto_err;
  logic [1:0]    arith_pid;
  logic [1:0]    shift_pid;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   rrp = 0;
  bit   mon_en = 1'b0;
  exp_t sb [2][$];
  int   mq [2][$];
  bit   mpend [NP];
  bit   mcls [NP];
  bit   merr [NP];
  bit   gnow [NP];
  int   seen [$];
  int   expb [4] = '{0, 1, 3, 2};

  always #5 c_clk = ~c_clk;

  calc1_op_arbiter #(.NPORT(4), .PIDW(2)) dut (
    .c_clk    (c_clk),
    .reset    (reset),
    .req_vld  (req_vld),
    .req_cls  (req_cls),
    .arith_rdy(arith_rdy),
    .shift_rdy(shift_rdy),
    .arith_gnt(arith_gnt),
    .shift_gnt(shift_gnt),
    .arith_pid(arith_pid),
    .shift_pid(shift_pid),
    .proto_err(proto_err)
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Reference model: per-unit FIFOs of port numbers.
  always @(posedge c_clk) begin
    bit pend0 [NP];
    bit gnext [NP];
    bit rdy [2];
    int hd [2];
    int start;
    int p;
    pend0 = mpend;
    gnext = '{default: 1'b0};
    if (reset) begin
      mq[0].delete();
      mq[1].delete();
      mpend = '{default: 1'b0};
      merr  = '{default: 1'b0};
      rrp   = 0;
    end else begin
      rdy[0] = arith_rdy;
      rdy[1] = shift_rdy;
      for (int u = 0; u < 2; u++)
        hd[u] = (mq[u].size() != 0) ? mq[u][0] : -1;
      for (int q = 0; q < NP; q++)
        if (req_vld[q] && pend0[q] && req_cls[q] != mcls[q])
          merr[q] = 1'b1;
      for (int q = 0; q < NP; q++) begin
        if (pend0[q] && !req_vld[q]) begin
          mpend[q] = 1'b0;
          for (int u = 0; u < 2; u++)
            for (int i = mq[u].size() - 1; i >= 0; i--)
              if (mq[u][i] == q) mq[u].delete(i);
        end
      end
      for (int u = 0; u < 2; u++) begin
        if (hd[u] >= 0 && rdy[u] && req_vld[hd[u]]) begin
          sb[u].push_back('{hd[u], cyc + 1});
          mpend[hd[u]] = 1'b0;
          gnext[hd[u]] = 1'b1;
          void'(mq[u].pop_front());
        end
      end
      start = 0;
`ifdef CALC1_ARB_RR_TIE_EN
      start = rrp;
`endif
      for (int k = 0; k < NP; k++) begin
        p = (start + k) % NP;
        if (req_vld[p] && !pend0[p] && !gnow[p]) begin
          mq[int'(req_cls[p])].push_back(p);
          mpend[p] = 1'b1;
          mcls[p]  = req_cls[p];
          rrp      = (p + 1) % NP;
        end
      end
    end
    gnow = gnext;
    cyc++;
  end

  task automatic check_unit(int u, logic [NP-1:0] g,
                            logic [1:0] pid);
    string nm;
    exp_t  e;
    nm = (u == 0) ? "arith" : "shift";
    if (g != '0) begin
      if (sb[u].size() == 0) begin
        chk({nm, "_unexpected_gnt"}, int'(g), 0);
      end else begin
        e = sb[u].pop_front();
        chk({nm, "_gnt"}, int'(g), 1 << e.port);
        chk({nm, "_pid"}, int'(pid), e.port);
        chk({nm, "_gnt_cycle"}, cyc, e.cyc);
      end
    end else begin
      chk({nm, "_idle_pid"}, int'(pid), 0);
      if (sb[u].size() != 0 && sb[u][0].cyc <= cyc) begin
        e = sb[u].pop_front();
        chk({nm, "_missing_gnt"}, int'(g), 1 << e.port);
      end
    end
  endtask

  always @(negedge c_clk) begin
    if (mon_en) begin
      logic [NP-1:0] me;
      for (int q = 0; q < NP; q++) me[q] = merr[q];
      check_unit(0, arith_gnt, arith_pid);
      check_unit(1, shift_gnt, shift_pid);
      chk("proto_err", int'(proto_err), int'(me));
      if (arith_gnt != '0) seen.push_back(int'(arith_pid));
    end
  end

  task automatic tick();
    @(negedge c_clk);
    #1;
  endtask

  // Ports drop their request in the cycle their grant is visible.
  task automatic run(int n);
    repeat (n) begin
      tick();
      for (int q = 0; q < NP; q++)
        if (gnow[q]) req_vld[q] = 1'b0;
    end
  endtask

  initial begin
    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("reset_arith_gnt", int'(arith_gnt), 0);
    chk("reset_shift_gnt", int'(shift_gnt), 0);
    chk("reset_proto_err", int'(proto_err), 0);

    // Single port 2 arith request.
    arith_rdy = 1'b1;
    shift_rdy = 1'b1;
    req_vld   = 4'b0100;
    tick();
    chk("single_early", int'(arith_gnt), 0);
    tick();
    chk("single_gnt", int'(arith_gnt), 4);
    chk("single_pid", int'(arith_pid), 2);
    req_vld = '0;
    tick();
    chk("single_once", int'(arith_gnt), 0);
    run(2);

    // Ports 0,1,3 together, then port 2.
    seen.delete();
    req_vld = 4'b1011;
    tick();
    req_vld[2] = 1'b1;
    run(6);
    chk("fcfs_count", seen.size(), 4);
`ifndef CALC1_ARB_RR_TIE_EN
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk("fcfs_order", seen[i], expb[i]);
`endif

    // Arith and shift in the same cycle.
    req_cls = 4'b0010;
    req_vld = 4'b0011;
    tick();
    tick();
    chk("dual_arith", int'(arith_gnt), 1);
    chk("dual_shift", int'(shift_gnt), 2);
    req_vld = '0;
    run(2);
    req_cls = '0;

    // Stalled unit keeps order.
    seen.delete();
    arith_rdy = 1'b0;
    req_vld   = 4'b0010;
    tick();
    req_vld = 4'b0011;
    run(4);
    chk("stall_none", seen.size(), 0);
    arith_rdy = 1'b1;
    run(4);
    chk("stall_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("stall_first", seen[0], 1);
      chk("stall_second", seen[1], 0);
    end

    // Head withdrawal.
    seen.delete();
    arith_rdy = 1'b0;
    req_vld   = 4'b1000;
    tick();
    req_vld = 4'b1001;
    tick();
    req_vld[3] = 1'b0;
    arith_rdy  = 1'b1;
    run(4);
    chk("withdraw_count", seen.size(), 1);
    if (seen.size() == 1) chk("withdraw_port", seen[0], 0);

    // Class flip while pending.
    seen.delete();
    arith_rdy = 1'b0;
    req_vld   = 4'b0010;
    tick();
    req_cls = 4'b0010;
    tick();
    chk("proto_set", int'(proto_err), 2);
    arith_rdy = 1'b1;
    run(3);
    chk("proto_count", seen.size(), 1);
    if (seen.size() == 1) chk("proto_port", seen[0], 1);
    chk("proto_sticky", int'(proto_err), 2);
    req_cls = '0;

    // Reset with three entries queued.
    arith_rdy = 1'b0;
    req_vld   = 4'b0111;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    req_vld = 4'b0100;
    chk("rst_arith_gnt", int'(arith_gnt), 0);
    chk("rst_shift_gnt", int'(shift_gnt), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    arith_rdy = 1'b1;
    tick();
    chk("rst_after_early", int'(arith_gnt), 0);
    tick();
    chk("rst_after_gnt", int'(arith_gnt), 4);
    req_vld = '0;
    run(2);

    // Random traffic.
    repeat (500) begin
      tick();
      for (int q = 0; q < NP; q++) begin
        if (req_vld[q]) begin
          if (gnow[q]) begin
            if ($urandom_range(0, 9) < 6) req_vld[q] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) begin
            req_vld[q] = 1'b0;
          end
        end else if ($urandom_range(0, 9) < 4) begin
          req_vld[q] = 1'b1;
          req_cls[q] = 1'($urandom_range(0, 1));
        end
      end
      arith_rdy = ($urandom_range(0, 3) != 0);
      shift_rdy = ($urandom_range(0, 3) != 0);
    end

    req_vld   = '0;
    arith_rdy = 1'b1;
    shift_rdy = 1'b1;
    run(4);
    chk("drain", sb[0].size() + sb[1].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
